// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C init sequencer.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BYTE,
        STOP,
        GAP,
        FINISH
    } seq_state_t;

    typedef logic [1:0] qtr_t;

    localparam int unsigned BITS_PER_BYTE = 9;
    localparam int unsigned QTRS_PER_XFER = 120;

endpackage

// File: rtl/i2c_byte_tx.sv
// Shifts one byte MSB first plus a released ACK bit, one quarter-bit per tick.
// Bus levels are presented one edge early (_c) so the owner can register the pins.
module i2c_byte_tx
    import i2c_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  qtr_t       qtr_i,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    input  logic       sda_i,
    output logic       scl_c,
    output logic       sda_oe_c,
    output logic       ack_ok_o,
    output logic       nack_o,
    output logic       done_c
);

    localparam int unsigned CNT_W = 4;

    logic [8:0]       shift_q, shift_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic             active_q, active_d;
    logic             last_bit;
    logic             bit_end;
    logic             ack_sample;
    qtr_t             qtr_next;

    assign last_bit   = (bit_q == CNT_W'(BITS_PER_BYTE - 1));
    assign bit_end    = active_q && tick_i && (qtr_i == 2'd3);
    assign ack_sample = active_q && tick_i && (qtr_i == 2'd2) && last_bit;
    assign qtr_next   = tick_i ? qtr_i + 2'd1 : qtr_i;
    assign done_c     = bit_end && last_bit;

    // Trailing 1 in the shifter releases SDA for the ACK bit
    always_comb begin
        shift_d  = shift_q;
        bit_d    = bit_q;
        active_d = active_q;
        if (load_i) begin
            shift_d  = {byte_i, 1'b1};
            bit_d    = '0;
            active_d = 1'b1;
        end else if (bit_end) begin
            if (last_bit) begin
                active_d = 1'b0;
            end else begin
                shift_d = {shift_q[7:0], 1'b1};
                bit_d   = bit_q + CNT_W'(1);
            end
        end
    end

    assign scl_c    = qtr_next[1];
    assign sda_oe_c = ~shift_d[8];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q  <= '1;
            bit_q    <= '0;
            active_q <= 1'b0;
            ack_ok_o <= 1'b0;
            nack_o   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            if (load_i) begin
                ack_ok_o <= 1'b0;
                nack_o   <= 1'b0;
            end else if (ack_sample) begin
                ack_ok_o <= ~sda_i;
                nack_o   <= sda_i;
            end
        end
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Write-only I2C master that replays a table of 16-bit words to one device.
// Each word is one transaction: address, high byte, low byte; stops on NACK.
module i2c_init_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 48_000_000,
    parameter int unsigned I2C_FREQ  = 100_000,
    parameter int unsigned N_ENTRIES = 8,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    localparam int unsigned IDX_W    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [IDX_W-1:0] tbl_idx_o,
    input  logic [15:0]      tbl_data_i,
    output logic             scl_o,
    output logic             sda_oe_o,
    input  logic             sda_i
);

    localparam int unsigned     QTR      = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned     CNT_W    = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    if (QTR < 2) begin : g_qtr_check
        $error("i2c_init_sequencer: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
    end

    seq_state_t       state_q, state_d;
    qtr_t             qtr_q, qtr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [15:0]      data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;

    logic             running;
    logic             tick;
    logic             frame_end;
    logic             tx_load;
    logic [7:0]       tx_byte;
    logic             tx_scl_c;
    logic             tx_sda_oe_c;
    logic             tx_ack_ok;
    logic             tx_nack;
    logic             tx_done_c;

    assign running   = state_q inside {START, BYTE, STOP, GAP};
    assign tick      = running && (cnt_q == CNT_W'(QTR - 1));
    assign frame_end = tick && (qtr_q == 2'd3);

    i2c_byte_tx u_tx (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tick_i   (tick),
        .qtr_i    (qtr_q),
        .load_i   (tx_load),
        .byte_i   (tx_byte),
        .sda_i    (sda_i),
        .scl_c    (tx_scl_c),
        .sda_oe_c (tx_sda_oe_c),
        .ack_ok_o (tx_ack_ok),
        .nack_o   (tx_nack),
        .done_c   (tx_done_c)
    );

    // Next-state, framing and next pin levels
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        data_d   = data_q;
        idx_d    = idx_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tx_load  = 1'b0;
        tx_byte  = '0;
        cnt_d    = running ? (tick ? '0 : cnt_q + CNT_W'(1)) : '0;
        qtr_d    = tick ? qtr_q + 2'd1 : qtr_q;
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;

        case (state_q)
            IDLE: begin
                qtr_d = '0;
                if (start_i) begin
                    state_d = START;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                // Word read one quarter in, once tbl_idx_o has settled
                if (tick && (qtr_q == 2'd0)) begin
                    data_d = tbl_data_i;
                end
                if (frame_end) begin
                    state_d = BYTE;
                    sel_d   = 2'd0;
                    tx_load = 1'b1;
                    tx_byte = {DEV_ADDR, 1'b0};
                end
            end
            BYTE: begin
                if (tx_done_c) begin
                    if (tx_nack || !tx_ack_ok) begin
                        err_d   = 1'b1;
                        state_d = STOP;
                    end else if (sel_q == 2'd2) begin
                        state_d = STOP;
                    end else begin
                        sel_d   = sel_q + 2'd1;
                        tx_load = 1'b1;
                        tx_byte = (sel_q == 2'd0) ? data_q[15:8] : data_q[7:0];
                    end
                end
            end
            STOP: begin
                if (frame_end) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (frame_end) begin
                    if (err_q || (idx_q == LAST_IDX)) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = START;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START: begin
                scl_d    = (qtr_d != 2'd3);
                sda_oe_d = (qtr_d != 2'd0);
            end
            BYTE: begin
                scl_d    = tx_scl_c;
                sda_oe_d = tx_sda_oe_c;
            end
            STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = ~qtr_d[1];
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            qtr_q    <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            qtr_q    <= qtr_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign tbl_idx_o = idx_q;
    assign scl_o     = scl_q;
    assign sda_oe_o  = sda_oe_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed bench for i2c_init_sequencer: I2C slave model, byte scoreboard, timing checks.
module tb_i2c_init_sequencer;

    localparam int unsigned N    = 8;
    localparam int          XFER = 240;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [2:0]  tbl_idx_o;
    logic [15:0] tbl_data_i;
    logic        scl_o;
    logic        sda_oe_o;
    logic        sda_line;

    logic [15:0] tbl [0:N-1];
    logic [7:0]  exp_q [$];

    logic [7:0]  obs_log [0:255];
    int          obs_n      = 0;
    int          rd         = 0;
    int          n_start    = 0;
    int          n_stop     = 0;
    int          bit_cnt    = 0;
    int          byte_no    = 0;
    int          nack_at    = -1;
    logic        ack_phase  = 1'b0;
    logic        slave_pull = 1'b0;
    logic        scl_p      = 1'b1;
    logic        sda_p      = 1'b1;
    logic        busy_p     = 1'b0;
    logic [7:0]  sh         = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign sda_line   = ~(sda_oe_o | slave_pull);
    assign tbl_data_i = tbl[tbl_idx_o];

    i2c_init_sequencer #(
        .CLK_FREQ  (800_000),
        .I2C_FREQ  (100_000),
        .N_ENTRIES (N),
        .DEV_ADDR  (7'h1A)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .tbl_idx_o  (tbl_idx_o),
        .tbl_data_i (tbl_data_i),
        .scl_o      (scl_o),
        .sda_oe_o   (sda_oe_o),
        .sda_i      (sda_line)
    );

    // Slave model: decodes START/STOP/bits, logs bytes, ACKs unless byte_no == nack_at
    always @(negedge clk) begin
        if (!rst_ni) begin
            bit_cnt    = 0;
            ack_phase  = 1'b0;
            slave_pull = 1'b0;
        end else begin
            if (busy_o && !busy_p) byte_no = 0;
            if (scl_o && scl_p && sda_p && !sda_line) begin
                n_start++;
                bit_cnt   = 0;
                ack_phase = 1'b0;
            end else if (scl_o && scl_p && !sda_p && sda_line) begin
                n_stop++;
            end else if (!scl_p && scl_o && bit_cnt < 8) begin
                sh = {sh[6:0], sda_line};
                bit_cnt++;
            end else if (scl_p && !scl_o) begin
                if (ack_phase) begin
                    slave_pull = 1'b0;
                    ack_phase  = 1'b0;
                    bit_cnt    = 0;
                end else if (bit_cnt == 8) begin
                    if (obs_n < 256) obs_log[obs_n] = sh;
                    obs_n++;
                    slave_pull = (byte_no != nack_at);
                    byte_no++;
                    ack_phase = 1'b1;
                end
            end
        end
        scl_p  = scl_o;
        sda_p  = sda_line;
        busy_p = busy_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input int i);
        exp_q.push_back(8'h34);
        exp_q.push_back(tbl[i][15:8]);
        exp_q.push_back(tbl[i][7:0]);
    endtask

    task automatic compare_bytes();
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd < obs_n && rd < 256) check("sda_byte", 32'(obs_log[rd]), 32'(e));
            else check("sda_byte_missing", 32'(rd < obs_n), 1);
            rd++;
        end
        check("byte_count", 32'(obs_n), 32'(rd));
    endtask

    task automatic kick();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Wait for done_o; lat counts clocks from the start_i cycle
    task automatic run_seq(input int poke_at, output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!done_o && lat < 4000) begin
            if (busy_o) busy_n++;
            start_i = (lat == poke_at);
            @(negedge clk);
            lat++;
        end
        start_i = 1'b0;
        lat     = lat + 1;
        check("done_seen", 32'(done_o), 1);
        check("busy_at_done", 32'(busy_o), 0);
    endtask

    task automatic quiet(input int n, output int dones);
        dones = 0;
        repeat (n) begin
            @(negedge clk);
            if (done_o) dones++;
        end
    endtask

    initial begin
        int lat, busy_n, dones, s0, p0, k;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < N; i++) tbl[i] = (i == 0) ? 16'h1E00 : {8'(i * 2), 8'(i)};
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl_o), 1);
        check("rst_sda_oe", 32'(sda_oe_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_idx", 32'(tbl_idx_o), 0);
        rst_ni = 1'b1;
        @(negedge clk);

        // Full table, all ACKed
        for (int i = 0; i < N; i++) push_entry(i);
        s0 = n_start; p0 = n_stop;
        kick();
        check("busy_after_start", 32'(busy_o), 1);
        run_seq(-1, lat, busy_n);
        check("full_latency", 32'(lat), 32'(N * XFER + 1));
        check("full_busy_clocks", 32'(busy_n), 32'(N * XFER));
        check("full_err", 32'(err_o), 0);
        check("full_idx", 32'(tbl_idx_o), 7);
        check("full_starts", 32'(n_start - s0), 8);
        check("full_stops", 32'(n_stop - p0), 8);
        compare_bytes();
        check("idle_scl", 32'(scl_o), 1);
        check("idle_sda_oe", 32'(sda_oe_o), 0);
        quiet(200, dones);
        check("full_single_done", 32'(dones), 0);

        // NACK on the address byte of entry 0
        nack_at = 0;
        exp_q.push_back(8'h34);
        s0 = n_start; p0 = n_stop;
        kick();
        run_seq(-1, lat, busy_n);
        check("nack0_latency", 32'(lat), 97);
        check("nack0_err", 32'(err_o), 1);
        check("nack0_idx", 32'(tbl_idx_o), 0);
        check("nack0_stops", 32'(n_stop - p0), 1);
        compare_bytes();
        quiet(300, dones);
        check("nack0_no_done", 32'(dones), 0);
        check("nack0_no_restart", 32'(n_start - s0), 1);

        // NACK on the low byte of entry 3
        nack_at = 11;
        for (int i = 0; i < 4; i++) push_entry(i);
        s0 = n_start;
        kick();
        run_seq(-1, lat, busy_n);
        check("nack3_latency", 32'(lat), 32'(4 * XFER + 1));
        check("nack3_err", 32'(err_o), 1);
        check("nack3_idx", 32'(tbl_idx_o), 3);
        check("nack3_starts", 32'(n_start - s0), 4);
        compare_bytes();

        // Restart clears err; a start pulse mid-sequence must be ignored
        nack_at = -1;
        for (int i = 0; i < N; i++) push_entry(i);
        s0 = n_start;
        kick();
        check("restart_err_clear", 32'(err_o), 0);
        check("restart_idx", 32'(tbl_idx_o), 0);
        run_seq(500, lat, busy_n);
        check("poke_latency", 32'(lat), 32'(N * XFER + 1));
        check("poke_busy_clocks", 32'(busy_n), 32'(N * XFER));
        check("poke_starts", 32'(n_start - s0), 8);
        check("poke_idx", 32'(tbl_idx_o), 7);
        check("poke_err", 32'(err_o), 0);
        compare_bytes();

        // Asynchronous reset in the middle of a byte
        kick();
        k = 0;
        while (!(scl_o == 1'b0 && sda_oe_o == 1'b1 && k > 20) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("midbyte_reached", 32'(k < 500), 1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_scl", 32'(scl_o), 1);
        check("arst_sda_oe", 32'(sda_oe_o), 0);
        check("arst_busy", 32'(busy_o), 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        rd = obs_n;
        for (int i = 0; i < N; i++) push_entry(i);
        s0 = n_start;
        kick();
        run_seq(-1, lat, busy_n);
        check("post_rst_latency", 32'(lat), 32'(N * XFER + 1));
        check("post_rst_starts", 32'(n_start - s0), 8);
        check("post_rst_idx", 32'(tbl_idx_o), 7);
        check("post_rst_err", 32'(err_o), 0);
        compare_bytes();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
Autonomous I2C write-only master that configures an external codec/peripheral over the board I2C pins after reset or on request. On start it walks a table of N_ENTRIES 16-bit words from entry 0 upward. Each word goes out as one I2C write transaction: device address, high byte, low byte. It sits between the system clock domain (clk, rst_n from clock_gen) and the i2c_scl_o / i2c_sda_io pins. The top level drives the pin as i2c_sda_io = sda_oe_o ? 1'b0 : 1'bz.

Parameters:
CLK_FREQ, 48_000_000, system clock frequency in Hz
I2C_FREQ, 100_000, SCL frequency in Hz; QTR = CLK_FREQ/(4*I2C_FREQ) clocks per quarter-bit, QTR >= 2 (elaboration assert)
N_ENTRIES, 8, table length, 1..256
DEV_ADDR, 7'h1A, 7-bit target device address

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  pulse; begins sequence when idle
busy_o  out  1  high from accepted start until done_o
done_o  out  1  one-cycle pulse at end of sequence (success or error)
err_o  out  1  sticky NACK flag; cleared on next accepted start
tbl_idx_o  out  $clog2(N_ENTRIES) (min 1)  current table index
tbl_data_i  in  16  table word at tbl_idx_o; must be combinational/stable, sampled at transaction start
scl_o  out  1  SCL, push-pull
sda_oe_o  out  1  1 = pull SDA low, 0 = release
sda_i  in  1  SDA pin readback

Behaviour:
- Reset values: scl_o=1, sda_oe_o=0, busy_o=0, done_o=0, err_o=0, tbl_idx_o=0. FSM=IDLE, tick counter=0.
- Tick: free counter that pulses every QTR clocks while busy and is held at 0 in IDLE. All bus changes occur on ticks.
- FSM: IDLE -> START -> BYTE(addr) -> BYTE(hi) -> BYTE(lo) -> STOP -> GAP -> (next entry: START | last: FINISH) -> IDLE.
- IDLE: start_i=1 latches err_o=0, tbl_idx_o=0, busy_o=1. start_i while busy is ignored with no effect.
- START, 4 quarters: Q0 SDA released/SCL high, Q1 SDA low, Q2 SDA low, Q3 SCL low. tbl_data_i latched into a shift register on entry.
- BYTE, 9 bits MSB first:
  - Each bit: Q0 SCL low, drive data (sda_oe_o = ~bit); Q1 SCL low; Q2 SCL high; Q3 SCL high.
  - 9th bit releases SDA. sda_i is sampled on the last clock of Q2.
  - Address byte = {DEV_ADDR,1'b0}, then tbl_data[15:8], then tbl_data[7:0].
- ACK: sda_i=0 continues. sda_i=1 (NACK) sets err_o=1 and goes directly to STOP, then FINISH; remaining entries are skipped.
- STOP, 4 quarters: Q0 SCL low/SDA low, Q1 SCL high, Q2 SDA released, Q3 hold.
- GAP: 4 quarters, bus idle (bus-free time). tbl_idx_o increments at GAP exit unless last entry or error.
- FINISH: done_o=1 for one clock, busy_o=0 same clock, return to IDLE. tbl_idx_o keeps its last value.
- Per-transaction length = (4 + 27*4 + 4 + 4) quarters = 120*QTR clocks. Full sequence = N_ENTRIES*120*QTR + 1 clocks from start to done.
- Reset mid-operation: outputs return to reset values asynchronously (bus released). Any partial transaction is abandoned; the slave recovers on the next START.
- Clock stretching is not supported; SCL is push-pull.

Decomposition:
- Package i2c_pkg:
  - seq_state_t enum: IDLE, START, BYTE, STOP, GAP, FINISH.
  - Quarter-phase typedef (2 bits).
  - Localparams: per-byte bit count 9, quarters per transaction 120.
- Sub-module i2c_byte_tx: shifts one byte plus ACK bit on the quarter tick. Ports: load/byte in, scl/sda_oe out, ack_ok/nack out, done pulse.
- The sequencer owns START/STOP/GAP framing, table indexing and error handling.

Test Plan:
- CLK_FREQ=800_000, I2C_FREQ=100_000 (QTR=2), N_ENTRIES=1, tbl[0]=16'h1E00, slave ACKs all -> SDA bytes 0x34,0x1E,0x00, START and STOP framing correct, done_o pulse 241 clocks after start, err_o=0.
- N_ENTRIES=8, tbl[i]=16'h(i*2)0(i) -> 8 transactions in index order 0..7, tbl_idx_o ends 7, exactly one done_o, busy_o high 1920 clocks.
- Slave NACKs address in entry 0 -> STOP follows the 9th bit, err_o=1, done_o pulse, tbl_idx_o=0, no further START.
- NACK on lo byte of entry 3 of 8 -> entries 0-2 complete, err_o=1, tbl_idx_o=3. A new start_i then clears err_o and restarts from 0.
- start_i pulsed mid-sequence -> ignored; transaction count and timing unchanged.
- rst_ni asserted mid-byte -> scl_o=1 and sda_oe_o=0 immediately. After release, a start_i produces a clean sequence from entry 0.
